regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Writeback scheduler and scoreboard for the 32x32 register bank (Banco_Registros).
- Arbitrates the bank's single write port between the single-cycle ALU result path and the long-latency load/store result path.
- Tracks registers with outstanding long-latency writes and stalls decode on RAW/WAW hazards.
- Drives RegWriteEn/rd/data of the bank directly from registered outputs.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive cycles the LSU may be refused before it gets forced priority; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  decode presents an instruction
- iss_rs1  in  5  source register 1
- iss_rs2  in  5  source register 2
- iss_rd  in  5  destination register
- iss_long  in  1  rd will be written by the LSU path
- iss_stall  out  1  hazard, decode must hold; combinational
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid  in  1  LSU writeback request
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  LSU result
- lsu_ready  out  1  LSU request accepted this cycle
- wr_en  out  1  to RegWriteEn
- wr_rd  out  5  to rd
- wr_data  out  XLEN  to data
- busy_mask  out  32  scoreboard state; bit 0 always 0

Behaviour:
- Reset (async, any time): wr_en=0, wr_rd=0, wr_data=0, busy_mask=0, starve_cnt=0, wr_src=0.
  - In-flight handshakes are dropped.
  - alu_ready/lsu_ready follow the combinational rules below once rst deasserts.
- Handshake: transfer occurs when valid && ready at a rising edge. Requesters hold rd/data stable while valid && !ready.
- Arbitration (combinational from state and inputs):
  - force = (starve_cnt == STARVE_LIMIT).
  - alu_ready = !(force && lsu_valid).
  - lsu_ready = !alu_valid || force.
  - Exactly one transfer per cycle at most.
- starve_cnt (4 bits):
  - Cleared to 0 on an LSU transfer or when lsu_valid=0.
  - Otherwise, while lsu_valid && !lsu_ready, incremented, saturating at STARVE_LIMIT.
- Write stage (1-cycle latency):
  - On a transfer, the next edge registers wr_rd, wr_data and wr_src (1=LSU).
  - wr_en = 1 only if the transferred rd != 0.
  - With no transfer, wr_en=0; wr_rd/wr_data hold their last values.
  - A transfer with rd=0 completes the handshake but never asserts wr_en.
- Scoreboard busy[31:1]:
  - Set: at the edge where iss_valid && !iss_stall && iss_long && iss_rd != 0, busy[iss_rd] <= 1.
  - Clear: at the edge where wr_en && wr_src=1, busy[wr_rd] <= 0. This is the same edge on which the bank captures the data, so the next-cycle combinational read sees the new value.
  - Set and clear of the same index on the same edge: set wins.
- iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]); index 0 never busy. iss_stall=0 when iss_valid=0.
- No internal buffering: back-pressure is the requester's responsibility.

Optional Feature:
- Macro: WB_SCHED_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt (32) and perf_conflict_cnt (32), both reset to 0.
  - perf_stall_cnt increments each cycle iss_stall=1.
  - perf_conflict_cnt increments each cycle alu_valid && lsu_valid.
  - Both wrap at 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-write: alu_valid=1, alu_rd=5, alu_data=0x1234; assert rst at the same edge -> wr_en=0, wr_rd=0, wr_data=0 immediately (async), busy_mask=0.
- ALU single write: alu_valid=1, rd=3, data=0xDEADBEEF for 1 cycle, lsu idle -> alu_ready=1; next cycle wr_en=1, wr_rd=3, wr_data=0xDEADBEEF; following cycle wr_en=0.
- Starvation (STARVE_LIMIT=4): alu_valid and lsu_valid held high, lsu_rd=7, lsu_data=0x55 -> lsu_ready=0 for 4 cycles, then lsu_ready=1 and alu_ready=0 in cycle 5; LSU write appears in cycle 6; counter returns to 0.
- Scoreboard RAW: issue iss_long=1, iss_rd=9 -> busy_mask=0x200; then iss_rs1=9 -> iss_stall=1; LSU write rd=9 -> busy_mask=0 on the wr_en edge and iss_stall drops the next cycle.
- Simultaneous set/clear: LSU wr_en for rd=12 on the same edge as a new long issue to rd=12 -> busy_mask bit 12 stays 1.
- x0: LSU transfer with rd=0 and long issue with iss_rd=0 -> lsu_ready=1, wr_en stays 0, busy_mask stays 0, iss_rs1=0 never stalls.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - writeback arbiter and long-latency scoreboard for the register bank
// Optional perf counters: define WB_SCHED_PERF_EN.
module regfile_wb_scheduler #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   input  logic [4:0]      iss_rd,
   input  logic            iss_long,
   output logic            iss_stall,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   output logic            wr_en,
   output logic [4:0]      wr_rd,
   output logic [XLEN-1:0] wr_data,
   output logic [31:0]     busy_mask
`ifdef WB_SCHED_PERF_EN
   ,
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_conflict_cnt
`endif
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  starve_cnt;
   logic        wr_src;
   logic        force_lsu;
   logic        alu_xfer;
   logic        lsu_xfer;
   logic        iss_set;
   logic [31:0] busy_nxt;

   assign force_lsu = (starve_cnt == LIMIT);
   assign alu_ready = !(force_lsu && lsu_valid);
   assign lsu_ready = !alu_valid || force_lsu;
   assign alu_xfer  = alu_valid && alu_ready;
   assign lsu_xfer  = lsu_valid && lsu_ready;

   assign iss_stall = iss_valid &&
                      (busy_mask[iss_rs1] || busy_mask[iss_rs2] || busy_mask[iss_rd]);
   assign iss_set   = iss_valid && !iss_stall && iss_long && (iss_rd != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (lsu_xfer || !lsu_valid) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Data and destination hold their last value when idle; only wr_en pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_rd   <= 5'd0;
         wr_data <= '0;
         wr_src  <= 1'b0;
      end else if (lsu_xfer) begin
         wr_en   <= (lsu_rd != 5'd0);
         wr_rd   <= lsu_rd;
         wr_data <= lsu_data;
         wr_src  <= 1'b1;
      end else if (alu_xfer) begin
         wr_en   <= (alu_rd != 5'd0);
         wr_rd   <= alu_rd;
         wr_data <= alu_data;
         wr_src  <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   // Clear is applied first so a same-edge set of the same register wins.
   always_comb begin
      busy_nxt = busy_mask;
      if (wr_en && wr_src) begin
         busy_nxt[wr_rd] = 1'b0;
      end
      if (iss_set) begin
         busy_nxt[iss_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_mask <= 32'd0;
      end else begin
         busy_mask <= busy_nxt;
      end
   end

`ifdef WB_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt    <= 32'd0;
         perf_conflict_cnt <= 32'd0;
      end else begin
         if (iss_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (alu_valid && lsu_valid) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - randomized scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

   localparam int XLEN         = 32;
   localparam int STARVE_LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            iss_valid;
   logic [4:0]      iss_rs1, iss_rs2, iss_rd;
   logic            iss_long;
   logic            iss_stall;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic            wr_en;
   logic [4:0]      wr_rd;
   logic [XLEN-1:0] wr_data;
   logic [31:0]     busy_mask;
`ifdef WB_SCHED_PERF_EN
   logic [31:0]     perf_stall_cnt;
   logic [31:0]     perf_conflict_cnt;
`endif

   regfile_wb_scheduler #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_long(iss_long), .iss_stall(iss_stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .busy_mask(busy_mask)
`ifdef WB_SCHED_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: set of pending registers, count of consecutive LSU refusals,
   // and the LSU write that frees a register one cycle after its handshake.
   bit         m_busy[32];
   int         m_refused;
   bit         m_clr_pend;
   logic [4:0] m_clr_rd;
   bit         last_a_x, last_l_x;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_refused  = 0;
      m_clr_pend = 1'b0;
      m_clr_rd   = 5'd0;
      exp_q.delete();
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = 32'd0;
      for (int i = 1; i < 32; i++) m[i] = m_busy[i];
      return m;
   endfunction

   task automatic idle_inputs();
      iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_long = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   // One cycle: check combinational outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      bit starved, a_rdy, l_rdy, stall;
      @(negedge clk);
      starved = (m_refused >= STARVE_LIMIT);
      a_rdy   = !(lsu_valid && starved);
      l_rdy   = !alu_valid || starved;
      stall   = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
      chk("alu_ready", alu_ready, a_rdy);
      chk("lsu_ready", lsu_ready, l_rdy);
      chk("iss_stall", iss_stall, stall);
      chk("busy_mask", busy_mask, model_mask());
      @(posedge clk);
      last_a_x = alu_valid && a_rdy;
      last_l_x = lsu_valid && l_rdy;
      if (last_a_x && alu_rd != 0) exp_q.push_back('{alu_rd, alu_data});
      if (last_l_x && lsu_rd != 0) exp_q.push_back('{lsu_rd, lsu_data});
      if (last_l_x || !lsu_valid) m_refused = 0;
      else m_refused++;
      if (m_clr_pend) m_busy[m_clr_rd] = 1'b0;
      if (iss_valid && !stall && iss_long && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_clr_pend = last_l_x && (lsu_rd != 0);
      m_clr_rd   = lsu_rd;
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && wr_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wr_en", {59'd0, wr_rd}, 64'hFFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_rd", wr_rd, e.rd);
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   initial begin
      int refusals;
      rst = 1'b1;
      idle_inputs();
      model_reset();
      last_a_x = 0; last_l_x = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_rd", wr_rd, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy_mask, 0);
      rst = 1'b0;

      // ALU single write
      alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
      step();
      chk("alu_wr_en", wr_en, 1);
      chk("alu_wr_rd", wr_rd, 3);
      idle_inputs();
      step();
      chk("alu_wr_en_drop", wr_en, 0);

      // Starvation: LSU refused STARVE_LIMIT times, then forced
      refusals = 0;
      alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h55;
      for (int i = 0; i < 10; i++) begin
         alu_data = i;
         step();
         if (last_l_x) break;
         refusals++;
      end
      chk("starve_refusals", refusals, STARVE_LIMIT);
      idle_inputs();
      step();
      chk("starve_lsu_wr_rd", wr_rd, 7);
      chk("starve_cnt_cleared", lsu_ready, 1);

      // Scoreboard RAW on x9
      iss_valid = 1; iss_long = 1; iss_rd = 9;
      step();
      idle_inputs();
      chk("raw_busy_set", busy_mask, 32'h200);
      iss_valid = 1; iss_rs1 = 9; iss_rd = 1;
      step();
      lsu_valid = 1; lsu_rd = 9; lsu_data = 32'hCAFE0009;
      step();
      lsu_valid = 0;
      step();
      step();
      chk("raw_busy_clear", busy_mask, 0);
      idle_inputs();
      step();

      // x0: handshake completes, no write, no busy bit
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFF;
      iss_valid = 1; iss_long = 1; iss_rd = 0; iss_rs1 = 0;
      step();
      idle_inputs();
      chk("x0_no_wr_en", wr_en, 0);
      step();
      chk("x0_busy", busy_mask, 0);

      // Same-edge clear and set on x12: set wins
      lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h1212;
      step();
      idle_inputs();
      iss_valid = 1; iss_long = 1; iss_rd = 12;
      step();
      idle_inputs();
      chk("setclr_bit12", busy_mask[12], 1);

      // Randomized traffic, requesters hold while refused
      for (int n = 0; n < 400; n++) begin
         if (!(alu_valid && !last_a_x)) begin
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 15));
            alu_data  = $urandom;
         end
         if (!(lsu_valid && !last_l_x)) begin
            lsu_valid = ($urandom_range(0, 1) != 0);
            lsu_rd    = 5'($urandom_range(0, 15));
            lsu_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 1) != 0);
         iss_long  = ($urandom_range(0, 1) != 0);
         iss_rs1   = 5'($urandom_range(0, 15));
         iss_rs2   = 5'($urandom_range(0, 15));
         iss_rd    = 5'($urandom_range(0, 15));
         step();
      end
      idle_inputs();
      repeat (2) step();
      chk("queue_drained", exp_q.size(), 0);

      // Reset on the edge that registers an ALU write
      alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
      iss_valid = 1; iss_long = 1; iss_rd = 14;
      step();
      chk("pre_rst_wr_en", wr_en, 1);
      rst = 1'b1;
      idle_inputs();
      #1;
      chk("async_rst_wr_en", wr_en, 0);
      chk("async_rst_wr_rd", wr_rd, 0);
      chk("async_rst_wr_data", wr_data, 0);
      chk("async_rst_busy", busy_mask, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) step();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
